// File: rtl/add16_seq_ctrl_pkg.sv
// Shared widths and FSM state encoding for the nibble-serial 16-bit adder.
package add16_seq_ctrl_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned NUM_NIB = DATA_W / NIB_W;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add16_seq_ctrl_cpa4.sv
// 4-bit combinational ripple-carry adder built from chained full-adder cells.
module cpa4
  import add16_seq_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  logic [NIB_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[NIB_W];

endmodule

// File: rtl/add16_seq_ctrl.sv
// Sequential 16-bit add/subtract: one nibble per cycle through a shared cpa4,
// valid/ready handshakes on request and result.
module add16_seq_ctrl
  import add16_seq_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  input  logic              sub,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] result,
  output logic              cout,
  output logic              ovf,
  output logic              busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIB - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic              carry;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] beff_r;

  logic [NIB_W-1:0]  a_nib;
  logic [NIB_W-1:0]  b_nib;
  logic [NIB_W-1:0]  s_nib;
  logic              c_nib;

  assign a_nib = a_r[{idx, 2'b00} +: NIB_W];
  assign b_nib = beff_r[{idx, 2'b00} +: NIB_W];

  cpa4 u_cpa4 (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .s    (s_nib),
    .cout (c_nib)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      a_r         <= '0;
      beff_r      <= '0;
      result      <= '0;
      cout        <= 1'b0;
      ovf         <= 1'b0;
      start_ready <= 1'b1;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid && start_ready) begin
            a_r         <= a;
            beff_r      <= b ^ {DATA_W{sub}};
            carry       <= sub ? 1'b1 : cin;
            idx         <= '0;
            state       <= RUN;
            start_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        RUN: begin
          result[{idx, 2'b00} +: NIB_W] <= s_nib;
          carry <= c_nib;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            // Carry into bit 15 recovered from the sum bit, since the chain is internal to cpa4.
            cout      <= c_nib;
            ovf       <= (a_nib[NIB_W-1] ^ b_nib[NIB_W-1] ^ s_nib[NIB_W-1]) ^ c_nib;
            state     <= DONE;
            busy      <= 1'b0;
            res_valid <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state       <= IDLE;
            res_valid   <= 1'b0;
            start_ready <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          start_ready <= 1'b1;
          res_valid   <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add16_seq_ctrl.sv
// Scoreboard bench for add16_seq_ctrl: expected results queued on accept, checked on output.
module tb_add16_seq_ctrl;

  typedef struct packed {
    logic [15:0] res;
    logic        co;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] result;
  logic        cout;
  logic        ovf;
  logic        busy;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  add16_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .cout        (cout),
    .ovf         (ovf),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ea, input logic [15:0] eb,
                                 input logic ecin, input logic esub);
    logic [16:0] full;
    logic [15:0] bop;
    exp_t        e;
    bop  = esub ? ~eb : eb;
    full = {1'b0, ea} + {1'b0, bop} + {16'd0, (esub ? 1'b1 : ecin)};
    e.res = full[15:0];
    e.co  = full[16];
    e.ov  = (ea[15] == bop[15]) && (full[15] != ea[15]);
    return e;
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (start_ready) return;
      @(posedge clk); #1;
    end
    chk("start_ready_timeout", {31'd0, start_ready}, 32'd1);
  endtask

  // Issue one operation; hold res_ready low for `hold` cycles in DONE with start_valid high.
  task automatic do_op(input logic [15:0] oa, input logic [15:0] ob,
                       input logic ocin, input logic osub, input int hold);
    exp_t e;
    int   lat;
    logic [15:0] held;
    wait_ready();
    a = oa; b = ob; cin = ocin; sub = osub; start_valid = 1'b1;
    sb.push_back(model(oa, ob, ocin, osub));
    @(posedge clk); #1;
    start_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    chk("busy_in_run", {31'd0, busy}, 32'd1);
    chk("start_ready_in_run", {31'd0, start_ready}, 32'd0);
    lat = 0;
    while (!res_valid && lat < 10) begin
      start_valid = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 4);
    held = result;
    for (int i = 0; i < hold; i++) begin
      start_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, res_valid}, 32'd1);
      chk("bp_start_ready", {31'd0, start_ready}, 32'd0);
      chk("bp_result_stable", {16'd0, result}, {16'd0, held});
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    e = sb.pop_front();
    chk("result", {16'd0, result}, {16'd0, e.res});
    chk("cout", {31'd0, cout}, {31'd0, e.co});
    chk("ovf", {31'd0, ovf}, {31'd0, e.ov});
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("idle_valid", {31'd0, res_valid}, 32'd0);
    chk("idle_start_ready", {31'd0, start_ready}, 32'd1);
    @(posedge clk); #1;
    chk("idle_hold_result", {16'd0, result}, {16'd0, e.res});
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_flags", {28'd0, cout, ovf, res_valid, busy}, 32'd0);
    chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 3);
    do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
    do_op(16'h0000, 16'h0000, 1'b1, 1'b1, 1);
    for (int i = 0; i < 6; i++)
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), i % 3);

    // Reset in the middle of RUN while idx=2; the in-flight op is discarded.
    wait_ready();
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; sub = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("midrst_result", {16'd0, result}, 32'd0);
    chk("midrst_flags", {28'd0, cout, ovf, res_valid, busy}, 32'd0);
    chk("midrst_start_ready", {31'd0, start_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    do_op(16'h0001, 16'h0002, 1'b0, 1'b0, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/add16_seq_ctrl.md
ADD16_SEQ_CTRL -- requirements
Module: add16_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start_valid, input, 1 bit: operation request.
REQ-004 SHALL have port start_ready, output, 1 bit: controller can accept a request.
REQ-005 SHALL have port a, input, 16 bits: operand A.
REQ-006 SHALL have port b, input, 16 bits: operand B.
REQ-007 SHALL have port cin, input, 1 bit: carry-in, used in add mode only.
REQ-008 SHALL have port sub, input, 1 bit: 1 = compute A - B.
REQ-009 SHALL have port res_valid, output, 1 bit: result available.
REQ-010 SHALL have port res_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port result, output, 16 bits: sum or difference.
REQ-012 SHALL have port cout, output, 1 bit: carry out of bit 15.
REQ-013 SHALL have port ovf, output, 1 bit: two's-complement overflow.
REQ-014 SHALL have port busy, output, 1 bit: high in RUN state.

Function
REQ-015 SHALL implement an FSM with three states: IDLE, RUN, DONE.
REQ-016 SHALL drive start_ready=1 only in IDLE; a request is accepted on the edge where start_valid and start_ready are both 1.
REQ-017 On acceptance SHALL latch a, sub, cin and effective B, where effective B = b XOR {16{sub}}; SHALL set carry register to sub ? 1 : cin, set nibble index to 0, and enter RUN.
REQ-018 Each RUN cycle SHALL add nibble[idx] of A, nibble[idx] of effective B and the carry register through one shared 4-bit ripple adder.
REQ-019 At the end of each RUN cycle SHALL store the 4-bit sum into result[4*idx+3:4*idx], store the adder carry into the carry register, and increment idx.
REQ-020 When idx=3 SHALL register cout = final carry and ovf = (carry into bit 15) XOR (carry out of bit 15), then enter DONE; the carry into bit 15 is A[15] XOR Beff[15] XOR sum[15].
REQ-021 Latency: res_valid SHALL rise exactly 4 clock edges after the accepting edge; accept-to-accept throughput SHALL be at least 5 cycles.
REQ-022 In DONE SHALL hold res_valid=1 with result, cout and ovf stable until res_ready=1, then return to IDLE on that edge.
REQ-023 start_valid SHALL be ignored in RUN and DONE; inputs a, b, cin and sub SHALL have no effect outside the acceptance edge.
REQ-024 In IDLE, result, cout and ovf SHALL retain their last completed values.
REQ-025 In RUN, result SHALL be partially updated and is not valid while res_valid=0.
REQ-026 Index wrap: idx SHALL be 2 bits and never exceed 3 in RUN.

Reset
REQ-027 Asserting rst at any time, including mid-RUN or in DONE, SHALL immediately force: state IDLE, idx=0, carry register 0, result=0x0000, cout=0, ovf=0, res_valid=0, busy=0, start_ready=1 (after release); any in-flight operation is discarded.
REQ-028 The first request SHALL be acceptable on the first rising edge after rst deasserts.

Structure
REQ-029 Shared package SHALL hold DATA_W=16, NIB_W=4, NUM_NIB=4 and the state enumeration (IDLE, RUN, DONE).
REQ-030 SHALL instantiate exactly one sub-module cpa4: 4-bit combinational ripple-carry adder (a[3:0], b[3:0], cin -> s[3:0], cout) built from full-adder cells with carry chained from bit 0 to bit 3.
REQ-031 Nibble selection, carry register, result register and FSM SHALL reside in add16_seq_ctrl.

Verification
REQ-032 Add: a=0x1234, b=0x4321, cin=0, sub=0 -> result=0x5555, cout=0, ovf=0, res_valid high 4 edges after accept.
REQ-033 Carry ripple across nibbles: a=0xFFFF, b=0x0001, cin=0 -> result=0x0000, cout=1, ovf=0.
REQ-034 Subtract: a=0x0005, b=0x0007, sub=1 -> result=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> result=0x7FFF, ovf=1.
REQ-035 Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> result=0x8000, cout=0, ovf=1.
REQ-036 Backpressure: hold res_ready=0 for 3 cycles in DONE while start_valid=1 -> result stable, start_ready=0, no new accept; on res_ready=1, IDLE next cycle.
REQ-037 Reset mid-op: assert rst at RUN idx=2 -> all outputs zero and state IDLE immediately; the next request a=0x0001, b=0x0002 -> result=0x0003.
